data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 112 +++++++++++
 tb/tb_data_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter.
// Port 0 (pipeline MEM stage) normally wins. Port 1 (debug/DMA) is forced
// through after MAX_WAIT consecutive denied cycles, so it cannot starve.
// Grants and memory drive are combinational. Read data is captured one
// cycle after the grant into a per-port register, with a one-cycle rvalid.
module data_mem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  // Four bits cover the full legal MAX_WAIT range of 1..15.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             force_p1;

  // Port 1 has waited long enough and takes this cycle even over port 0.
  assign force_p1 = p1_req && (wait_cnt == WAIT_LIMIT);

  // Fixed priority to port 0, except when port 1 is forced; nothing is
  // granted while reset is held.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst) begin
      if (force_p1) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  // Route the granted port to memory; an idle cycle drives all zeros.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    if (p0_gnt) begin
      mem_access_addr = p0_addr;
      mem_write_data  = p0_wdata;
      mem_write_en    = p0_we;
    end else if (p1_gnt) begin
      mem_access_addr = p1_addr;
      mem_write_data  = p1_wdata;
      mem_write_en    = p1_we;
    end
  end

  // Count consecutive denied port-1 cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Capture port-0 read data and pulse its rvalid one cycle after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rdata  <= '0;
      p0_rvalid <= 1'b0;
    end else if (p0_gnt && !p0_we) begin
      p0_rdata  <= mem_read_data;
      p0_rvalid <= 1'b1;
    end else begin
      p0_rvalid <= 1'b0;
    end
  end

  // Capture port-1 read data and pulse its rvalid one cycle after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_rdata  <= '0;
      p1_rvalid <= 1'b0;
    end else if (p1_gnt && !p1_we) begin
      p1_rdata  <= mem_read_data;
      p1_rvalid <= 1'b1;
    end else begin
      p1_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbitration rules and an expected-contents copy of the data memory.
module tb_data_mem_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              p0_req = 1'b0, p0_we = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0;
  logic              p1_req = 1'b0, p1_we = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_write_en;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                denied_streak;
  logic [DATA_W-1:0] exp_rdata0, exp_rdata1;
  logic              exp_rvalid0, exp_rvalid1;

  // Data memory attached to the arbiter: combinational read, clocked write.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  assign mem_read_data = mem[mem_access_addr];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
  end

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_data(mem_read_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    denied_streak = 0;
    exp_rdata0    = '0;
    exp_rdata1    = '0;
    exp_rvalid0   = 1'b0;
    exp_rvalid1   = 1'b0;
  endtask

  // One full clock cycle: entered and left 1ns after a rising edge.
  task automatic applyStimulus(input logic r0, input logic w0,
                               input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input logic r1, input logic w1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    logic g0, g1, forced;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic ew;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #2;
    forced = r1 && (denied_streak >= MAX_WAIT);
    g1 = r1 && (forced || !r0);
    g0 = r0 && !forced;
    ea = g0 ? a0 : (g1 ? a1 : '0);
    ed = g0 ? d0 : (g1 ? d1 : '0);
    ew = g0 ? w0 : (g1 ? w1 : 1'b0);
    checkOutput("p0_gnt", 32'(p0_gnt), 32'(g0));
    checkOutput("p1_gnt", 32'(p1_gnt), 32'(g1));
    checkOutput("mem_addr", 32'(mem_access_addr), 32'(ea));
    checkOutput("mem_wdata", 32'(mem_write_data), 32'(ed));
    checkOutput("mem_we", 32'(mem_write_en), 32'(ew));
    @(posedge clk);
    #1;
    exp_rvalid0 = g0 && !w0;
    exp_rvalid1 = g1 && !w1;
    if (exp_rvalid0) exp_rdata0 = ref_mem[a0];
    if (exp_rvalid1) exp_rdata1 = ref_mem[a1];
    if (g0 && w0) ref_mem[a0] = d0;
    if (g1 && w1) ref_mem[a1] = d1;
    if (r1 && !g1) denied_streak = (denied_streak < MAX_WAIT) ? denied_streak + 1 : MAX_WAIT;
    else denied_streak = 0;
    checkOutput("p0_rvalid", 32'(p0_rvalid), 32'(exp_rvalid0));
    checkOutput("p1_rvalid", 32'(p1_rvalid), 32'(exp_rvalid1));
    checkOutput("p0_rdata", 32'(p0_rdata), 32'(exp_rdata0));
    checkOutput("p1_rdata", 32'(p1_rdata), 32'(exp_rdata1));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic [ADDR_W-1:0] wr_addr [8];
  logic [DATA_W-1:0] wr_data [8];
  int p0_pattern_grants;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    modelReset();

    // Reset state, with port 0 trying to write throughout
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'd9; p0_wdata = 16'hDEAD;
    #3;
    checkOutput("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_write_en), 32'd0);
    checkOutput("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    checkOutput("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_mem9", 32'(mem[9]), 32'd0);
    rst = 1'b1;

    // Port 0 write then read of address 5
    applyStimulus(1'b1, 1'b1, 16'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 16'd5, 16'h0000, 1'b0, 1'b0, '0, '0);
    checkOutput("p0_read5", 32'(p0_rdata), 32'h1234);
    idleCycle();

    // Port 1 read of address 5 with port 0 idle
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'd5, 16'h0000);
    checkOutput("p1_read5", 32'(p1_rdata), 32'h1234);
    checkOutput("p0_rdata_kept", 32'(p0_rdata), 32'h1234);

    // Both ports held: port 1 forced once every MAX_WAIT+1 cycles
    p0_pattern_grants = 0;
    for (int c = 0; c < 3 * (MAX_WAIT + 1); c++) begin
      applyStimulus(1'b1, 1'b0, 16'd5, '0, 1'b1, 1'b0, 16'd5, '0);
      p0_pattern_grants += int'(exp_rvalid0);
    end
    checkOutput("starve_p0_count", 32'(p0_pattern_grants), 32'(3 * MAX_WAIT));
    idleCycle();

    // Simultaneous writes with counter clear: port 0 wins
    applyStimulus(1'b1, 1'b1, 16'd2, 16'hAAAA, 1'b1, 1'b1, 16'd2, 16'h5555);
    checkOutput("mem2", 32'(mem[2]), 32'hAAAA);
    idleCycle();

    // Build up some port-1 wait, then reset in the middle of a p1 read
    applyStimulus(1'b1, 1'b0, 16'd2, '0, 1'b1, 1'b0, 16'd2, '0);
    applyStimulus(1'b1, 1'b0, 16'd2, '0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'd5, '0);
    applyStimulus(1'b1, 1'b0, 16'd5, '0, 1'b1, 1'b0, 16'd2, '0);
    p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'd2;
    #2;
    checkOutput("pre_rst_p1_gnt", 32'(p1_gnt), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_p1_gnt", 32'(p1_gnt), 32'd0);
    checkOutput("midrst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    checkOutput("midrst_p1_rdata", 32'(p1_rdata), 32'd0);
    checkOutput("midrst_p0_rdata", 32'(p0_rdata), 32'd0);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'd2; p0_wdata = 16'hBEEF;
    #1;
    checkOutput("midrst_mem_we", 32'(mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_rvalid", 32'(p1_rvalid), 32'd0);
    checkOutput("rst_hold_mem2", 32'(mem[2]), 32'hAAAA);
    rst = 1'b1;
    modelReset();
    idleCycle();
    // A stale wait count would force port 1 early here
    for (int c = 0; c < MAX_WAIT + 2; c++) begin
      applyStimulus(1'b1, 1'b0, 16'd2, '0, 1'b1, 1'b0, 16'd5, '0);
    end
    idleCycle();

    // Eight random writes through alternating ports, read back through the other
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = ADDR_W'($urandom);
      wr_data[i] = DATA_W'($urandom);
      if (i % 2 == 0) applyStimulus(1'b1, 1'b1, wr_addr[i], wr_data[i], 1'b0, 1'b0, '0, '0);
      else            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, wr_addr[i], wr_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, wr_addr[i], '0);
      else            applyStimulus(1'b1, 1'b0, wr_addr[i], '0, 1'b0, 1'b0, '0, '0);
    end

    // Random mixed traffic on a small address window to force collisions
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
                    DATA_W'($urandom),
                    1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
                    DATA_W'($urandom));
    end
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
